// File: rtl/mem_access_if.sv
// Shared widths/op codes for the memory stage and the byte-wide RAM port bundle.
// The master side belongs to mem_access; the slave side is the RAM/arbiter.
package mem_access_pkg;
    localparam int REG_ADDR_W   = 5;
    localparam int REG_W        = 32;
    localparam int MEM_W        = 32;
    localparam int ALUOP_W      = 8;
    localparam int STALL_W      = 6;
    localparam int STALL_EX_MEM = 4;
    localparam logic STOP       = 1'b1;

    localparam logic [ALUOP_W-1:0] EX_LB  = 8'h20;
    localparam logic [ALUOP_W-1:0] EX_LH  = 8'h21;
    localparam logic [ALUOP_W-1:0] EX_LW  = 8'h22;
    localparam logic [ALUOP_W-1:0] EX_LBU = 8'h23;
    localparam logic [ALUOP_W-1:0] EX_LHU = 8'h24;
    localparam logic [ALUOP_W-1:0] EX_SB  = 8'h28;
    localparam logic [ALUOP_W-1:0] EX_SH  = 8'h29;
    localparam logic [ALUOP_W-1:0] EX_SW  = 8'h2A;
endpackage

interface mem_access_if;
    logic        ram_req;
    logic        ram_gnt;
    logic [31:0] ram_addr;
    logic        ram_wr;
    logic [7:0]  ram_dout;
    logic [7:0]  ram_din;

    modport master (
        output ram_req,
        output ram_addr,
        output ram_wr,
        output ram_dout,
        input  ram_gnt,
        input  ram_din
    );

    modport slave (
        input  ram_req,
        input  ram_addr,
        input  ram_wr,
        input  ram_dout,
        output ram_gnt,
        output ram_din
    );
endinterface

// File: rtl/mem_access.sv
// Memory pipeline stage: services loads/stores one byte per cycle over the shared
// RAM port, stalling the pipeline until the write-back triple is ready.
//
//   state    | meaning
//   ---------+---------------------------------------------------------------
//   S_IDLE   | pass-through; a memory op requests byte 0 here
//   S_ACCESS | issuing bytes 1..N-1 and/or capturing returned load bytes
//   S_DONE   | access complete, result presented until EX/MEM is released
module mem_access
    import mem_access_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,

    input  logic [REG_ADDR_W-1:0] mem_wd,
    input  logic                  mem_wreg,
    input  logic [REG_W-1:0]      mem_wdata,
    input  logic [MEM_W-1:0]      mem_mem_addr,
    input  logic [ALUOP_W-1:0]    mem_aluop,
    input  logic [STALL_W-1:0]    stall,

    mem_access_if.master          ram,

    output logic                  stallreq_mem,
    output logic [REG_ADDR_W-1:0] wb_wd,
    output logic                  wb_wreg,
    output logic [REG_W-1:0]      wb_wdata
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACCESS = 2'd1;
    localparam logic [1:0] S_DONE   = 2'd2;

    logic [1:0]  state;
    logic [1:0]  state_nxt;
    logic [2:0]  idx;
    logic [2:0]  idx_nxt;
    logic [31:0] acc;
    logic        cap_pend;

    logic        is_load;
    logic        is_store;
    logic        is_mem;
    logic        ld_signed;
    logic [2:0]  nbytes;

    logic [2:0]  issue_idx;
    logic        want_issue;
    logic        issue;
    logic        last_issue;
    logic [1:0]  cap_byte;
    logic [31:0] byte_addr;
    logic [7:0]  store_byte;
    logic [31:0] ld_ext;

    logic        unused_stall;
    assign unused_stall = ^{stall[STALL_W-1:STALL_EX_MEM+1], stall[STALL_EX_MEM-1:0]};

    always_comb begin
        is_load   = 1'b0;
        is_store  = 1'b0;
        ld_signed = 1'b0;
        nbytes    = 3'd0;
        case (mem_aluop)
            EX_LB:  begin is_load  = 1'b1; ld_signed = 1'b1; nbytes = 3'd1; end
            EX_LH:  begin is_load  = 1'b1; ld_signed = 1'b1; nbytes = 3'd2; end
            EX_LW:  begin is_load  = 1'b1; nbytes = 3'd4; end
            EX_LBU: begin is_load  = 1'b1; nbytes = 3'd1; end
            EX_LHU: begin is_load  = 1'b1; nbytes = 3'd2; end
            EX_SB:  begin is_store = 1'b1; nbytes = 3'd1; end
            EX_SH:  begin is_store = 1'b1; nbytes = 3'd2; end
            EX_SW:  begin is_store = 1'b1; nbytes = 3'd4; end
            default: ;
        endcase
    end

    assign is_mem = is_load | is_store;

    // Byte 0 is always requested from IDLE, so idx only matters inside ACCESS.
    assign issue_idx  = (state == S_ACCESS) ? idx : 3'd0;
    assign want_issue = is_mem &&
                        ((state == S_IDLE) || ((state == S_ACCESS) && (idx < nbytes)));
    assign issue      = want_issue && ram.ram_gnt;
    assign last_issue = issue && (issue_idx == (nbytes - 3'd1));
    assign byte_addr  = mem_mem_addr + {29'd0, issue_idx};
    assign store_byte = mem_wdata[{issue_idx[1:0], 3'b000} +: 8];

    // The byte returning now was issued when idx was one lower.
    assign cap_byte   = idx[1:0] - 2'd1;

    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        case (state)
            S_IDLE: begin
                idx_nxt = 3'd0;
                if (issue) begin
                    idx_nxt   = 3'd1;
                    state_nxt = (is_store && (nbytes == 3'd1)) ? S_DONE : S_ACCESS;
                end
            end
            S_ACCESS: begin
                if (!is_mem) begin
                    state_nxt = S_IDLE;
                    idx_nxt   = 3'd0;
                end else begin
                    if (issue) begin
                        idx_nxt = idx + 3'd1;
                    end
                    if (is_store && last_issue) begin
                        state_nxt = S_DONE;
                    end else if (is_load && cap_pend && (idx == nbytes)) begin
                        state_nxt = S_DONE;
                    end
                end
            end
            S_DONE: begin
                if (stall[STALL_EX_MEM] != STOP) begin
                    state_nxt = S_IDLE;
                    idx_nxt   = 3'd0;
                end
            end
            default: begin
                state_nxt = S_IDLE;
                idx_nxt   = 3'd0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= S_IDLE;
            idx      <= 3'd0;
            cap_pend <= 1'b0;
        end else begin
            state    <= state_nxt;
            idx      <= idx_nxt;
            cap_pend <= issue && is_load;
        end
    end

    // A capture is taken even when the grant is low in the returning cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc <= '0;
        end else if (cap_pend) begin
            acc[{cap_byte, 3'b000} +: 8] <= ram.ram_din;
        end else if (state == S_IDLE) begin
            acc <= '0;
        end
    end

    always_comb begin
        ld_ext = acc;
        if (nbytes == 3'd1) begin
            ld_ext = ld_signed ? {{24{acc[7]}}, acc[7:0]} : {24'd0, acc[7:0]};
        end else if (nbytes == 3'd2) begin
            ld_ext = ld_signed ? {{16{acc[15]}}, acc[15:0]} : {16'd0, acc[15:0]};
        end
    end

    // Outputs are forced low while reset is held, even if EX/MEM still shows an op.
    always_comb begin
        ram.ram_req  = 1'b0;
        ram.ram_addr = '0;
        ram.ram_wr   = 1'b0;
        ram.ram_dout = '0;
        stallreq_mem = 1'b0;
        wb_wd        = '0;
        wb_wreg      = 1'b0;
        wb_wdata     = '0;
        if (rst) begin
            ram.ram_req  = want_issue;
            ram.ram_addr = want_issue ? byte_addr : '0;
            ram.ram_wr   = issue && is_store;
            ram.ram_dout = (issue && is_store) ? store_byte : 8'd0;
            stallreq_mem = is_mem && (state != S_DONE);
            wb_wd        = mem_wd;
            wb_wreg      = mem_wreg;
            wb_wdata     = ((state == S_DONE) && is_load) ? ld_ext : mem_wdata;
        end
    end

endmodule

// File: tb/tb_mem_access.sv
// Randomized scoreboard bench for mem_access: a byte-addressed memory model predicts
// every RAM access and every write-back result, checked by a negedge monitor.
module tb_mem_access;
    import mem_access_pkg::*;

    localparam logic [7:0] EX_NOP = 8'h00;
    localparam logic [7:0] EX_ADD = 8'h01;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [4:0]  mem_wd = '0;
    logic        mem_wreg = 1'b0;
    logic [31:0] mem_wdata = '0;
    logic [31:0] mem_mem_addr = '0;
    logic [7:0]  mem_aluop = EX_NOP;
    logic [5:0]  stall;
    logic        stallreq_mem;
    logic [4:0]  wb_wd;
    logic        wb_wreg;
    logic [31:0] wb_wdata;
    logic        hold_stop = 1'b0;

    mem_access_if bus();

    assign stall = {1'b0, stallreq_mem | hold_stop, 4'b0000};

    mem_access dut (
        .clk          (clk),
        .rst          (rst),
        .mem_wd       (mem_wd),
        .mem_wreg     (mem_wreg),
        .mem_wdata    (mem_wdata),
        .mem_mem_addr (mem_mem_addr),
        .mem_aluop    (mem_aluop),
        .stall        (stall),
        .ram          (bus),
        .stallreq_mem (stallreq_mem),
        .wb_wd        (wb_wd),
        .wb_wreg      (wb_wreg),
        .wb_wdata     (wb_wdata)
    );

    always #5 clk = ~clk;

    typedef struct { logic [31:0] addr; logic wr; logic [7:0] data; } acc_t;
    typedef struct { logic [4:0] wd; logic wreg; logic [31:0] wdata; int base; } wb_t;

    acc_t exp_acc[$];
    wb_t  exp_wb[$];
    logic [7:0] ram_mem [int unsigned];
    logic [7:0] mdl_mem [int unsigned];

    int tests = 0;
    int errors = 0;
    int retire_cnt = 0;
    int stall_cnt = 0;
    int deny_cnt = 0;
    int cyc = 0;
    int deny_cyc = -1;
    int gnt_pct = 100;
    logic op_active = 1'b0;
    logic rd_pending = 1'b0;
    logic [7:0] rd_val = '0;

    logic [7:0] ops [10] = '{EX_LB, EX_LH, EX_LW, EX_LBU, EX_LHU,
                             EX_SB, EX_SH, EX_SW, EX_ADD, EX_NOP};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        tests++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, want, $time);
        end
    endtask

    task automatic finish_tb();
        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    endtask

    function automatic logic [7:0] dflt(input logic [31:0] a);
        return a[7:0] ^ a[15:8] ^ 8'h5A;
    endfunction

    function automatic logic [7:0] ram_rd(input logic [31:0] a);
        if (ram_mem.exists(a)) return ram_mem[a];
        return dflt(a);
    endfunction

    function automatic logic [7:0] mdl_rd(input logic [31:0] a);
        if (mdl_mem.exists(a)) return mdl_mem[a];
        return dflt(a);
    endfunction

    task automatic preload(input logic [31:0] a, input logic [7:0] b);
        ram_mem[a] = b;
        mdl_mem[a] = b;
    endtask

    // Reference: a load/store is N little-endian bytes at addr+i (mod 2^32).
    task automatic model_op(input logic [7:0] op, input logic [4:0] wd, input logic wreg,
                            input logic [31:0] wdata, input logic [31:0] addr);
        int n;
        bit ld, sx;
        logic [31:0] v, a;
        wb_t w;
        acc_t e;
        n = 0; ld = 0; sx = 0;
        case (op)
            EX_LB:  begin n = 1; ld = 1; sx = 1; end
            EX_LH:  begin n = 2; ld = 1; sx = 1; end
            EX_LW:  begin n = 4; ld = 1; end
            EX_LBU: begin n = 1; ld = 1; end
            EX_LHU: begin n = 2; ld = 1; end
            EX_SB:  n = 1;
            EX_SH:  n = 2;
            EX_SW:  n = 4;
            default: n = 0;
        endcase
        w.wd = wd; w.wreg = wreg; w.wdata = wdata; w.base = 0;
        v = '0;
        for (int i = 0; i < n; i++) begin
            a = addr + 32'(i);
            e.addr = a;
            e.wr = !ld;
            if (ld) begin
                e.data = 8'h00;
                v = v | (32'(mdl_rd(a)) << (8 * i));
            end else begin
                e.data = 8'(wdata >> (8 * i));
                mdl_mem[a] = e.data;
            end
            exp_acc.push_back(e);
        end
        if (n > 0) begin
            w.base = ld ? n + 1 : n;
            if (ld) begin
                if (sx && n == 1) v = 32'($signed(v[7:0]));
                else if (sx && n == 2) v = 32'($signed(v[15:0]));
                w.wdata = v;
            end
        end
        exp_wb.push_back(w);
    endtask

    // Arbiter and RAM read-data return, both changed just after the clock edge.
    initial begin
        bus.ram_gnt = 1'b0;
        bus.ram_din = 8'h00;
        forever begin
            @(posedge clk);
            #2;
            cyc++;
            bus.ram_gnt = (cyc == deny_cyc) ? 1'b0 : ($urandom_range(99) < gnt_pct);
            bus.ram_din = rd_pending ? rd_val : 8'($urandom);
            rd_pending  = 1'b0;
        end
    end

    always @(negedge clk) begin
        acc_t e;
        wb_t w;
        if (!rst) begin
            stall_cnt = 0;
            deny_cnt  = 0;
        end else begin
            if (bus.ram_req && bus.ram_gnt) begin
                if (exp_acc.size() == 0) begin
                    tests++;
                    errors++;
                    $display("FAIL extra_access: addr %h wr %b, expected no access", bus.ram_addr, bus.ram_wr);
                end else begin
                    e = exp_acc.pop_front();
                    check("access_addr", bus.ram_addr, e.addr);
                    check("access_wr", {31'd0, bus.ram_wr}, {31'd0, e.wr});
                    if (e.wr) check("access_wdata", {24'd0, bus.ram_dout}, {24'd0, e.data});
                end
                if (bus.ram_wr) begin
                    ram_mem[bus.ram_addr] = bus.ram_dout;
                end else begin
                    rd_pending = 1'b1;
                    rd_val     = ram_rd(bus.ram_addr);
                end
            end else begin
                check("no_issue_wr", {31'd0, bus.ram_wr}, 32'd0);
                check("no_issue_dout", {24'd0, bus.ram_dout}, 32'd0);
            end
            if (stallreq_mem) stall_cnt++;
            if (bus.ram_req && !bus.ram_gnt) deny_cnt++;
            if (op_active && !stallreq_mem && !stall[4]) begin
                if (exp_wb.size() == 0) begin
                    tests++;
                    errors++;
                    $display("FAIL wb_extra: got %h, expected no result", wb_wdata);
                end else begin
                    w = exp_wb.pop_front();
                    check("wb_wd", {27'd0, wb_wd}, {27'd0, w.wd});
                    check("wb_wreg", {31'd0, wb_wreg}, {31'd0, w.wreg});
                    check("wb_wdata", wb_wdata, w.wdata);
                    check("stall_cycles", 32'(stall_cnt), 32'(w.base + deny_cnt));
                end
                stall_cnt = 0;
                deny_cnt  = 0;
                op_active = 1'b0;
                retire_cnt++;
            end
        end
    end

    task automatic drive(input logic [7:0] op, input logic [4:0] wd, input logic wreg,
                         input logic [31:0] wdata, input logic [31:0] addr);
        mem_aluop = op; mem_wd = wd; mem_wreg = wreg; mem_wdata = wdata; mem_mem_addr = addr;
    endtask

    task automatic run_op(input logic [7:0] op, input logic [4:0] wd, input logic wreg,
                          input logic [31:0] wdata, input logic [31:0] addr,
                          input int hold, input int deny_k);
        int start, n, held;
        @(posedge clk);
        #1;
        model_op(op, wd, wreg, wdata, addr);
        drive(op, wd, wreg, wdata, addr);
        hold_stop = (hold > 0);
        deny_cyc  = (deny_k > 0) ? cyc + deny_k : -1;
        op_active = 1'b1;
        start = retire_cnt;
        n = 0;
        held = 0;
        while (retire_cnt == start && n < 300) begin
            @(negedge clk);
            #1;
            n++;
            if (hold_stop && !stallreq_mem && retire_cnt == start) begin
                held++;
                if (held >= hold) begin
                    @(posedge clk);
                    #1;
                    hold_stop = 1'b0;
                end
            end
        end
        if (retire_cnt == start) begin
            tests++;
            errors++;
            $display("FAIL op_timeout: op %h addr %h never completed, expected completion", op, addr);
            finish_tb();
        end
    endtask

    task automatic drive_nop();
        @(posedge clk);
        #1;
        drive(EX_NOP, 5'd0, 1'b0, 32'd0, 32'd0);
    endtask

    initial begin
        logic [7:0] op;
        logic [31:0] base;

        drive(EX_NOP, 5'd3, 1'b1, 32'h0000ABCD, 32'h10);
        #3;
        check("rst_ram_req", {31'd0, bus.ram_req}, 32'd0);
        check("rst_ram_wr", {31'd0, bus.ram_wr}, 32'd0);
        check("rst_ram_addr", bus.ram_addr, 32'd0);
        check("rst_ram_dout", {24'd0, bus.ram_dout}, 32'd0);
        check("rst_stallreq", {31'd0, stallreq_mem}, 32'd0);
        check("rst_wb_wd", {27'd0, wb_wd}, 32'd0);
        check("rst_wb_wreg", {31'd0, wb_wreg}, 32'd0);
        check("rst_wb_wdata", wb_wdata, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        drive(EX_NOP, 5'd0, 1'b0, 32'd0, 32'd0);

        preload(32'h100, 8'h11); preload(32'h101, 8'h22);
        preload(32'h102, 8'h33); preload(32'h103, 8'h44);
        preload(32'h7, 8'h80);
        preload(32'hFFFF_FFFF, 8'h34); preload(32'h0, 8'h92);
        preload(32'h204, 8'hA1); preload(32'h205, 8'hB2);
        preload(32'h206, 8'hC3); preload(32'h207, 8'hD4);

        gnt_pct = 100;
        run_op(EX_ADD, 5'd5, 1'b1, 32'h0000_1234, 32'h0, 0, 0);
        check("add_same_cycle_wdata", wb_wdata, 32'h0000_1234);
        run_op(EX_LW,  5'd6, 1'b1, 32'h0, 32'h100, 0, 0);
        run_op(EX_LB,  5'd7, 1'b1, 32'h0, 32'h7, 0, 0);
        run_op(EX_LBU, 5'd8, 1'b1, 32'h0, 32'h7, 0, 0);
        run_op(EX_LH,  5'd9, 1'b1, 32'h0, 32'hFFFF_FFFF, 0, 0);
        run_op(EX_SW,  5'd0, 1'b0, 32'hDEAD_BEEF, 32'h2, 2, 2);
        run_op(EX_LW,  5'd10, 1'b1, 32'h0, 32'h2, 0, 0);

        // Reset in the middle of a word load, after byte 1 has been issued.
        @(posedge clk);
        #1;
        model_op(EX_LW, 5'd9, 1'b1, 32'h0, 32'h200);
        drive(EX_LW, 5'd9, 1'b1, 32'h0, 32'h200);
        deny_cyc  = -1;
        op_active = 1'b1;
        @(negedge clk);
        @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        check("midrst_ram_req", {31'd0, bus.ram_req}, 32'd0);
        check("midrst_ram_addr", bus.ram_addr, 32'd0);
        check("midrst_stallreq", {31'd0, stallreq_mem}, 32'd0);
        check("midrst_wb_wd", {27'd0, wb_wd}, 32'd0);
        check("midrst_wb_wreg", {31'd0, wb_wreg}, 32'd0);
        check("midrst_wb_wdata", wb_wdata, 32'd0);
        exp_acc.delete();
        exp_wb.delete();
        op_active  = 1'b0;
        rd_pending = 1'b0;
        hold_stop  = 1'b0;
        drive(EX_NOP, 5'd0, 1'b0, 32'd0, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        run_op(EX_LW,  5'd11, 1'b1, 32'h0, 32'h204, 0, 0);
        run_op(EX_LHU, 5'd12, 1'b1, 32'h0, 32'h206, 0, 0);

        run_op(EX_SB,  5'd0, 1'b0, 32'h1234_56C3, 32'h40, 0, 0);
        run_op(EX_LBU, 5'd13, 1'b1, 32'h0, 32'h40, 0, 0);
        run_op(EX_SH,  5'd0, 1'b0, 32'h0000_8F01, 32'hFFFF_FFFF, 1, 1);
        run_op(EX_LH,  5'd14, 1'b1, 32'h0, 32'hFFFF_FFFF, 0, 3);

        for (int i = 0; i < 80; i++) begin
            op = ops[$urandom_range(0, 9)];
            case ($urandom_range(0, 2))
                0: base = 32'h0000_0300;
                1: base = 32'hFFFF_FFF8;
                default: base = 32'h0000_0000;
            endcase
            gnt_pct = $urandom_range(40, 100);
            run_op(op, 5'($urandom), 1'($urandom), $urandom,
                   base + 32'($urandom_range(0, 11)), $urandom_range(0, 2), 0);
        end

        drive_nop();
        repeat (3) @(posedge clk);
        #1;
        check("access_queue_drained", 32'(exp_acc.size()), 32'd0);
        check("wb_queue_drained", 32'(exp_wb.size()), 32'd0);
        finish_tb();
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish, expected completion");
        errors++;
        $fatal(1, "[TB] %0d tests run, %0d failed", tests, errors);
    end

endmodule
